// File: rtl/uart_word_pkg.sv
// Shared types and constants for the UART word bridge.
package uart_word_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_LOAD,
    TX_STROBE,
    TX_WAIT_BUSY,
    TX_WAIT_DONE
  } tx_state_e;

  localparam int TIMEOUT_CYCLES_DEF = 120000;

  // Byte-index width, clog2(bytes); never narrower than one bit.
  function automatic int idx_width(input int bytes);
    return (bytes <= 1) ? 1 : $clog2(bytes);
  endfunction

endpackage

// File: rtl/uart_word_tx.sv
// TX side of the UART word bridge: FSM that serialises one word
// into byte strobes, pacing each byte on the core's busy flag.
module uart_word_tx
  import uart_word_pkg::*;
#(
  parameter int N         = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] word_in,
  input  logic         word_in_valid,
  output logic         word_in_ready,
  input  logic         is_transmitting,
  output logic [7:0]   tx_byte,
  output logic         tx_valid
);

  localparam int BYTES = N / 8;
  localparam int IW    = idx_width(BYTES);

  tx_state_e      state_q, state_d;
  logic [N-1:0]   word_q, word_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [7:0]     tx_byte_q, tx_byte_d;
  logic [7:0]     head;
  logic [N-1:0]   rest;

  // The word is consumed from one end so the next byte is always at head.
  assign head = MSB_FIRST ? word_q[N-1 -: 8] : word_q[7:0];
  assign rest = MSB_FIRST ? (word_q << 8) : (word_q >> 8);

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    idx_d     = idx_q;
    tx_byte_d = tx_byte_q;
    unique case (state_q)
      TX_IDLE: begin
        if (word_in_valid) begin
          word_d  = word_in;
          idx_d   = '0;
          state_d = TX_LOAD;
        end
      end
      TX_LOAD: begin
        if (!is_transmitting) begin
          tx_byte_d = head;
          word_d    = rest;
          state_d   = TX_STROBE;
        end
      end
      TX_STROBE: state_d = TX_WAIT_BUSY;
      TX_WAIT_BUSY: begin
        if (is_transmitting) state_d = TX_WAIT_DONE;
      end
      TX_WAIT_DONE: begin
        if (!is_transmitting) begin
          if (idx_q == IW'(BYTES - 1)) begin
            state_d = TX_IDLE;
          end else begin
            idx_d     = idx_q + 1'b1;
            tx_byte_d = head;
            word_d    = rest;
            state_d   = TX_STROBE;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= TX_IDLE;
      word_q    <= '0;
      idx_q     <= '0;
      tx_byte_q <= '0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      idx_q     <= idx_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  assign word_in_ready = (state_q == TX_IDLE);
  assign tx_valid      = (state_q == TX_STROBE);
  assign tx_byte       = tx_byte_q;

endmodule

// File: rtl/uart_word_bridge.sv
// Byte<->word bridge for a UART core. Define UART_WORD_BRIDGE_TIMEOUT_EN
// to discard partial RX words after TIMEOUT_CYCLES idle cycles.
module uart_word_bridge
  import uart_word_pkg::*;
#(
  parameter int N              = 16,
  parameter bit MSB_FIRST      = 1'b1,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx_valid,
  input  logic [7:0]   rx_byte,
  output logic [N-1:0] word_out,
  output logic         word_out_valid,
  input  logic         word_out_ready,
  input  logic [N-1:0] word_in,
  input  logic         word_in_valid,
  output logic         word_in_ready,
  input  logic         is_transmitting,
  output logic [7:0]   tx_byte,
  output logic         tx_valid,
  output logic         rx_overrun,
  output logic         rx_timeout
);

  localparam int BYTES = N / 8;
  localparam int CW    = idx_width(BYTES);

  if (N % 8 != 0 || N < 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("uart_word_bridge: illegal N or TIMEOUT_CYCLES");
  end

  logic [N-1:0]  asm_q, asm_d;
  logic [N-1:0]  word_out_q, word_out_d;
  logic          wov_q, wov_d;
  logic          ovr_q, ovr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_base;
  logic [N-1:0]  byte_ext;
  logic [N-1:0]  asm_nxt;
  logic          complete;
  logic          accept;

  assign byte_ext = N'(rx_byte);
  assign asm_nxt  = MSB_FIRST ? ((asm_q << 8) | byte_ext)
                              : ((asm_q >> 8) | (byte_ext << (N - 8)));

`ifdef UART_WORD_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] idle_q, idle_d;
  logic          to_q;
  logic          to_hit;

  assign to_hit = (cnt_q != '0) && (idle_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    idle_d = '0;
    if (!rx_valid && !to_hit && cnt_q != '0) idle_d = idle_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
      to_q   <= 1'b0;
    end else begin
      idle_q <= idle_d;
      to_q   <= to_hit;
    end
  end

  // A byte landing on the timeout cycle counts as byte 0 of a new word.
  assign cnt_base   = to_hit ? '0 : cnt_q;
  assign rx_timeout = to_q;
`else
  assign cnt_base   = cnt_q;
  assign rx_timeout = 1'b0;
`endif

  assign complete = rx_valid && (cnt_base == CW'(BYTES - 1));
  assign accept   = wov_q && word_out_ready;

  always_comb begin
    asm_d      = asm_q;
    cnt_d      = cnt_base;
    word_out_d = word_out_q;
    wov_d      = wov_q && !accept;
    ovr_d      = 1'b0;
    if (rx_valid) begin
      asm_d = asm_nxt;
      cnt_d = complete ? '0 : cnt_base + 1'b1;
    end
    if (complete) begin
      if (!wov_q || accept) begin
        word_out_d = asm_nxt;
        wov_d      = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q      <= '0;
      word_out_q <= '0;
      wov_q      <= 1'b0;
      ovr_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      asm_q      <= asm_d;
      word_out_q <= word_out_d;
      wov_q      <= wov_d;
      ovr_q      <= ovr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign word_out       = word_out_q;
  assign word_out_valid = wov_q;
  assign rx_overrun     = ovr_q;

  uart_word_tx #(
    .N         (N),
    .MSB_FIRST (MSB_FIRST)
  ) u_tx (
    .clk             (clk),
    .rst_n           (rst_n),
    .word_in         (word_in),
    .word_in_valid   (word_in_valid),
    .word_in_ready   (word_in_ready),
    .is_transmitting (is_transmitting),
    .tx_byte         (tx_byte),
    .tx_valid        (tx_valid)
  );

endmodule

// File: tb/tb_uart_word_bridge.sv
// Bench for uart_word_bridge: a 16-bit MSB-first and a 32-bit
// LSB-first instance, each with a 10-cycle-busy UART model.
module tb_uart_word_bridge;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_rxv, a_wov, a_rdy, a_wiv, a_wir;
  logic        a_busy, a_txv, a_ovr, a_to;
  logic [7:0]  a_rxb, a_txb;
  logic [15:0] a_wout, a_win;

  logic        b_rxv, b_wov, b_rdy, b_wiv, b_wir;
  logic        b_busy, b_txv, b_ovr, b_to;
  logic [7:0]  b_rxb, b_txb;
  logic [31:0] b_wout, b_win;

  uart_word_bridge #(
    .N(16), .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(50)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(a_rxv), .rx_byte(a_rxb),
    .word_out(a_wout), .word_out_valid(a_wov),
    .word_out_ready(a_rdy),
    .word_in(a_win), .word_in_valid(a_wiv),
    .word_in_ready(a_wir),
    .is_transmitting(a_busy),
    .tx_byte(a_txb), .tx_valid(a_txv),
    .rx_overrun(a_ovr), .rx_timeout(a_to)
  );

  uart_word_bridge #(
    .N(32), .MSB_FIRST(1'b0), .TIMEOUT_CYCLES(50)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(b_rxv), .rx_byte(b_rxb),
    .word_out(b_wout), .word_out_valid(b_wov),
    .word_out_ready(b_rdy),
    .word_in(b_win), .word_in_valid(b_wiv),
    .word_in_ready(b_wir),
    .is_transmitting(b_busy),
    .tx_byte(b_txb), .tx_valid(b_txv),
    .rx_overrun(b_ovr), .rx_timeout(b_to)
  );

  // UART core models: busy for 10 cycles after each strobe.
  int a_bc, b_bc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_bc <= 0;
      b_bc <= 0;
    end else begin
      if (a_txv) a_bc <= 10;
      else if (a_bc != 0) a_bc <= a_bc - 1;
      if (b_txv) b_bc <= 10;
      else if (b_bc != 0) b_bc <= b_bc - 1;
    end
  end
  assign a_busy = (a_bc != 0);
  assign b_busy = (b_bc != 0);

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  logic [15:0] a_rxq[$];
  logic [7:0]  a_txq[$];
  logic [7:0]  b_txq[$];
  int a_txn = 0, b_txn = 0, a_ovn = 0, a_ton = 0;

  // Scoreboard: pop expected values as the DUTs produce output.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_wov && a_rdy) begin
        if (a_rxq.size() == 0) chk("rx_unexpected", a_wout, 32'hx);
        else chk("rx_word", a_wout, a_rxq.pop_front());
      end
      if (a_txv) begin
        a_txn++;
        if (a_txq.size() == 0) chk("tx16_unexpected", a_txb, 32'hx);
        else chk("tx16_byte", a_txb, a_txq.pop_front());
      end
      if (b_txv) begin
        b_txn++;
        if (b_txq.size() == 0) chk("tx32_unexpected", b_txb, 32'hx);
        else chk("tx32_byte", b_txb, b_txq.pop_front());
      end
      if (a_ovr) a_ovn++;
      if (a_to) a_ton++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] b);
    a_rxb = b;
    a_rxv = 1'b1;
    tick();
    a_rxv = 1'b0;
  endtask

  task automatic tx_word_a(input logic [15:0] w);
    int k, n0;
    k = 0;
    while (!a_wir && k < 200) begin tick(); k++; end
    chk("tx16_start", a_wir, 1);
    a_txq.push_back(w[15:8]);
    a_txq.push_back(w[7:0]);
    n0 = a_txn;
    a_win = w;
    a_wiv = 1'b1;
    tick();
    a_wiv = 1'b0;
    k = 0;
    while (!a_wir && k < 500) begin tick(); k++; end
    chk("tx16_done", a_wir, 1);
    chk("tx16_pulses", a_txn - n0, 2);
  endtask

  task automatic tx_word_b(input logic [31:0] w);
    int k, n0;
    k = 0;
    while (!b_wir && k < 200) begin tick(); k++; end
    chk("tx32_start", b_wir, 1);
    for (int i = 0; i < 4; i++) b_txq.push_back(w[8*i +: 8]);
    n0 = b_txn;
    b_win = w;
    b_wiv = 1'b1;
    tick();
    b_wiv = 1'b0;
    k = 0;
    while (!b_wir && k < 500) begin tick(); k++; end
    chk("tx32_done", b_wir, 1);
    chk("tx32_pulses", b_txn - n0, 4);
  endtask

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [15:0] exp;
  } rx_vec_t;

  rx_vec_t     rxv[4];
  logic [31:0] txv[3];

  initial begin
    int n0, k;
    rxv[0] = '{8'hAB, 8'hCD, 16'hABCD};
    rxv[1] = '{8'h00, 8'hFF, 16'h00FF};
    rxv[2] = '{8'hFF, 8'h00, 16'hFF00};
    rxv[3] = '{8'h5A, 8'hA5, 16'h5AA5};
    txv[0] = 32'h11223344;
    txv[1] = 32'hDEADBEEF;
    txv[2] = 32'h00000080;

    rst_n = 1'b0;
    a_rxv = 0; a_rxb = 0; a_rdy = 1; a_win = 0; a_wiv = 0;
    b_rxv = 0; b_rxb = 0; b_rdy = 1; b_win = 0; b_wiv = 0;
    repeat (3) tick();
    chk("rst_word_out", a_wout, 0);
    chk("rst_wov", a_wov, 0);
    chk("rst_tx_byte", a_txb, 0);
    chk("rst_tx_valid", a_txv, 0);
    chk("rst_overrun", a_ovr, 0);
    chk("rst_timeout", a_to, 0);
    chk("rst_wir", a_wir, 1);
    chk("rst_wir32", b_wir, 1);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      a_rxq.push_back(rxv[i].exp);
      send_a(rxv[i].b0);
      chk("rx_not_early", a_wov, 0);
      send_a(rxv[i].b1);
      chk("rx_latency", a_wov, 1);
      chk("rx_word_now", a_wout, rxv[i].exp);
      tick();
      tick();
    end

    // Overrun: second word dropped while the first is held.
    a_rdy = 1'b0;
    n0 = a_ovn;
    a_rxq.push_back(16'h0102);
    send_a(8'h01);
    send_a(8'h02);
    send_a(8'h03);
    send_a(8'h04);
    tick();
    chk("ovr_pulses", a_ovn - n0, 1);
    chk("ovr_held_word", a_wout, 16'h0102);
    chk("ovr_held_valid", a_wov, 1);
    a_rdy = 1'b1;
    tick();
    chk("ovr_accepted", a_wov, 0);

    // Accept of the held word coincides with the next completion.
    a_rdy = 1'b0;
    n0 = a_ovn;
    a_rxq.push_back(16'h1111);
    send_a(8'h11);
    send_a(8'h11);
    a_rxq.push_back(16'h2233);
    send_a(8'h22);
    a_rxb = 8'h33;
    a_rxv = 1'b1;
    a_rdy = 1'b1;
    tick();
    a_rxv = 1'b0;
    chk("same_cyc_valid", a_wov, 1);
    chk("same_cyc_word", a_wout, 16'h2233);
    tick();
    tick();
    chk("same_cyc_no_ovr", a_ovn - n0, 0);

    n0 = a_ton;
`ifdef UART_WORD_BRIDGE_TIMEOUT_EN
    send_a(8'hAA);
    repeat (60) tick();
    a_rxq.push_back(16'hBBCC);
    send_a(8'hBB);
    send_a(8'hCC);
    tick();
    chk("timeout_pulses", a_ton - n0, 1);
`else
    a_rxq.push_back(16'hAABB);
    send_a(8'hAA);
    repeat (60) tick();
    send_a(8'hBB);
    tick();
    chk("no_timeout", a_ton - n0, 0);
    chk("partial_kept", a_wout, 16'hAABB);
`endif
    tick();

    foreach (txv[i]) tx_word_b(txv[i]);
    chk("tx_byte_hold", b_txb, 8'h00);
    tx_word_b(32'h11223344);
    chk("tx_byte_hold2", b_txb, 8'h11);

    // RX and TX on the same instance at once.
    fork
      tx_word_a(16'hC3E1);
      begin
        a_rxq.push_back(16'h1234);
        send_a(8'h12);
        send_a(8'h34);
      end
    join

    // Reset while the second TX byte is pending.
    k = 0;
    while (!a_wir && k < 200) begin tick(); k++; end
    a_txq.push_back(8'h12);
    n0 = a_txn;
    a_win = 16'h1234;
    a_wiv = 1'b1;
    tick();
    a_wiv = 1'b0;
    k = 0;
    while (a_txn == n0 && k < 100) begin tick(); k++; end
    chk("rst_first_byte", a_txn - n0, 1);
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_txv", a_txv, 0);
    chk("midrst_wir", a_wir, 1);
    chk("midrst_txb", a_txb, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_txv", a_txv, 0);
    tx_word_a(16'h5A5A);

    repeat (5) tick();
    chk("rxq_empty", a_rxq.size(), 0);
    chk("txq16_empty", a_txq.size(), 0);
    chk("txq32_empty", b_txq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_word_bridge.md
UART_WORD_BRIDGE -- requirements
Module: uart_word_bridge

Interface
REQ-001 Param N, default 16: word width in bits; SHALL be a multiple of 8 and at least 8 (BYTES = N/8).
REQ-002 Param MSB_FIRST, default 1: 1 = first byte on the wire is word[N-1:N-8]; 0 = first byte is word[7:0], on both RX and TX.
REQ-003 Param TIMEOUT_CYCLES, default 120000: inter-byte idle limit in clk cycles, used only when the timeout feature is compiled in.
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 rx_valid  in  1  one-cycle strobe from the UART core: rx_byte is valid.
REQ-007 rx_byte  in  8  received byte.
REQ-008 word_out  out  N  assembled word.
REQ-009 word_out_valid  out  1  word_out is valid; held until accepted.
REQ-010 word_out_ready  in  1  consumer accepts when valid && ready.
REQ-011 word_in  in  N  word to transmit.
REQ-012 word_in_valid  in  1  transmit request.
REQ-013 word_in_ready  out  1  high only in TX_IDLE; the word is captured when valid && ready.
REQ-014 is_transmitting  in  1  UART core busy flag.
REQ-015 tx_byte  out  8  byte to the UART core.
REQ-016 tx_valid  out  1  one-cycle transmit strobe to the UART core.
REQ-017 rx_overrun  out  1  one-cycle pulse: a byte was dropped.
REQ-018 rx_timeout  out  1  one-cycle pulse: a partial word was discarded; tied 0 when the feature is compiled out.

Function
REQ-019 RX: each rx_valid SHALL shift rx_byte into the assembly register at the position set by MSB_FIRST and increment byte_cnt.
REQ-020 RX: on the byte that makes byte_cnt equal BYTES, the next cycle SHALL present word_out with word_out_valid=1 and clear byte_cnt to 0 (latency 1 cycle).
REQ-021 RX: word_out and word_out_valid SHALL stay stable until valid && ready.
REQ-022 RX: while the output is held, assembly of the next word SHALL continue.
REQ-023 RX overrun: if a word completes while word_out_valid=1 and ready=0, the new word SHALL be dropped, the held word kept, and rx_overrun pulsed.
REQ-024 RX accept-and-complete in the same cycle: the held word SHALL be accepted and the new word loaded, with no overrun.
REQ-025 TX FSM states: TX_IDLE -> TX_LOAD -> TX_STROBE -> TX_WAIT_BUSY -> TX_WAIT_DONE.
REQ-026 TX_IDLE: on word_in_valid, capture word_in, set idx=0, go to TX_LOAD.
REQ-027 TX_LOAD: wait for is_transmitting=0, then go to TX_STROBE.
REQ-028 TX_STROBE: drive tx_valid=1 for exactly one cycle with tx_byte = byte idx in MSB_FIRST order, then go to TX_WAIT_BUSY.
REQ-029 TX_WAIT_BUSY: wait for is_transmitting=1, then go to TX_WAIT_DONE.
REQ-030 TX_WAIT_DONE: on is_transmitting=0, if idx=BYTES-1 go to TX_IDLE, else increment idx and go to TX_STROBE.
REQ-031 tx_byte SHALL hold its last value outside TX_STROBE.
REQ-032 RX and TX SHALL be fully independent; simultaneous activity SHALL not interact.

Reset
REQ-033 While rst_n=0, all of the following SHALL be 0 and the FSM in TX_IDLE: word_out, word_out_valid, tx_byte, tx_valid, rx_overrun, rx_timeout, byte_cnt, idx, idle counter.
REQ-034 word_in_ready SHALL be 1 at reset.
REQ-035 Reset mid-word or mid-transmit SHALL discard partial state; no tx_valid SHALL appear in the first cycle after release.

Configuration
REQ-036 Macro UART_WORD_BRIDGE_TIMEOUT_EN defined: an idle counter SHALL clear on every rx_valid and count while 0<byte_cnt<BYTES.
REQ-037 With the macro defined, on reaching TIMEOUT_CYCLES the block SHALL clear byte_cnt and pulse rx_timeout once.
REQ-038 With the macro defined, a byte arriving in the same cycle as the timeout SHALL start a new word as its byte 0.
REQ-039 Macro undefined: no idle counter SHALL exist, partial words SHALL persist indefinitely, and rx_timeout SHALL be constant 0.

Structure
REQ-040 Package uart_word_pkg SHALL hold the TX state enum, the byte-index width function clog2(BYTES), and the default TIMEOUT_CYCLES constant.
REQ-041 One sub-module, uart_word_tx, SHALL contain the TX FSM and serialiser; RX assembly SHALL stay in the top module.

Verification
REQ-042 N=16, MSB_FIRST=1, rx bytes 0xAB,0xCD, ready=1 -> word_out=0xABCD, valid one cycle after the second byte.
REQ-043 N=32, MSB_FIRST=0, word_in=0x11223344 with a UART model (10-cycle busy) -> tx_byte 0x44,0x33,0x22,0x11, exactly 4 tx_valid pulses, then word_in_ready=1.
REQ-044 N=16, ready=0, 4 bytes 01 02 03 04 -> word_out=0x0102 held, one rx_overrun pulse, 0x0304 lost.
REQ-045 Timeout feature, TIMEOUT_CYCLES=50: byte 0xAA, idle 60 cycles, then 0xBB,0xCC -> one rx_timeout pulse, word_out=0xBBCC.
REQ-046 rst_n low during the second byte of a TX -> tx_valid=0, FSM in TX_IDLE; a new word_in=0x5A5A sends 0x5A,0x5A cleanly.
